// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a single-ported word memory.
// Port 0 is the core load/store path, port 1 the loader/debug path.
// A request accepted in IDLE is issued to memory in GRANT; reads wait one
// cycle in RESP for the memory data and return it with an rvalid pulse.
// Optional feature: define ARB_RR_EN for round-robin contention handling;
// without it port 0 always wins contention (fixed priority).
module mem_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [DATA_W-1:0] addr0,
    input  logic [DATA_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state_p0;
    state_t state_nx;

    // Accepted command, captured when a request is sampled in IDLE
    logic              win_p0;
    logic              we_p0;
    logic [DATA_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;

    logic any_req;
    logic pick1;
    logic accept;

    assign any_req = req0 | req1;
    assign accept  = (state_p0 == IDLE) & any_req;

`ifdef ARB_RR_EN
    // rr_ptr=1 means port 1 is favoured on the next contention
    logic rr_ptr;

    // Port 1 wins when alone, or under contention when it is its turn
    always_comb begin
        pick1 = req1 & (~req0 | rr_ptr);
    end

    // Pointer moves only when a grant is actually issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_ptr <= 1'b0;
        else if (state_p0 == GRANT)
            rr_ptr <= ~win_p0;
    end
`else
    // Fixed priority: port 1 wins only when port 0 is not requesting
    always_comb begin
        pick1 = req1 & ~req0;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_p0 <= IDLE;
        else
            state_p0 <= state_nx;
    end

    // Next-state logic: writes finish in GRANT, reads add a RESP cycle
    always_comb begin
        state_nx = state_p0;
        case (state_p0)
            IDLE:    if (any_req) state_nx = GRANT;
            GRANT:   state_nx = we_p0 ? IDLE : RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs: grant and memory enable exist only in GRANT
    always_comb begin
        busy   = (state_p0 != IDLE);
        mem_en = (state_p0 == GRANT);
        gnt0   = (state_p0 == GRANT) & ~win_p0;
        gnt1   = (state_p0 == GRANT) &  win_p0;
    end

    // Capture the winner's command at the end of the sampling cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_p0   <= 1'b0;
            we_p0    <= 1'b0;
            addr_p0  <= '0;
            wdata_p0 <= '0;
        end else if (accept) begin
            win_p0   <= pick1;
            we_p0    <= pick1 ? we1    : we0;
            addr_p0  <= pick1 ? addr1  : addr0;
            wdata_p0 <= pick1 ? wdata1 : wdata0;
        end
    end

    // ---- memory command stage: driven straight from the captured copy ----
    assign mem_rw    = we_p0;
    assign mem_addr  = addr_p0;
    assign mem_wdata = wdata_p0;

    // ---- response stage: memory data is valid in RESP, returned next cycle ----
    // Return read data to the winner only; the other port keeps its value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            if (state_p0 == RESP) begin
                if (win_p0) begin
                    rvalid1 <= 1'b1;
                    rdata1  <= mem_rdata;
                end else begin
                    rvalid0 <= 1'b1;
                    rdata0  <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural word memory.
// Inputs change and outputs are observed on the falling clock edge.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_en, mem_rw;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    int tests;
    int fails;

    logic [31:0] mem [0:255];

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: read data appears the cycle after a read command
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_rw)
                mem[mem_addr[7:0]] <= mem_wdata;
            else
                mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        @(negedge clk);
        tests++; if ({gnt0, gnt1, mem_en, mem_rw, busy} !== 5'b0) begin fails++; $display("FAIL reset_ctrl: got %b expected 00000", {gnt0, gnt1, mem_en, mem_rw, busy}); end
        tests++; if ({rvalid0, rvalid1} !== 2'b0) begin fails++; $display("FAIL reset_rvalid: got %b expected 00", {rvalid0, rvalid1}); end
        tests++; if ({mem_addr, mem_wdata} !== 64'h0) begin fails++; $display("FAIL reset_mem: got %h expected 0", {mem_addr, mem_wdata}); end
        tests++; if ({rdata0, rdata1} !== 64'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", {rdata0, rdata1}); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_write();
        req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
        @(negedge clk);
        tests++; if ({gnt0, gnt1, mem_en, mem_rw, busy} !== 5'b10111) begin fails++; $display("FAIL wr_grant: got %b expected 10111", {gnt0, gnt1, mem_en, mem_rw, busy}); end
        tests++; if (mem_addr !== 32'h10) begin fails++; $display("FAIL wr_addr: got %h expected 00000010", mem_addr); end
        tests++; if (mem_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_data: got %h expected deadbeef", mem_wdata); end
        req0 = 0;
        @(negedge clk);
        tests++; if ({gnt0, mem_en, busy, rvalid0} !== 4'b0) begin fails++; $display("FAIL wr_done: got %b expected 0000", {gnt0, mem_en, busy, rvalid0}); end
    endtask

    task automatic test_read_port1();
        req1 = 1; we1 = 0; addr1 = 32'h10;
        @(negedge clk);
        tests++; if ({gnt0, gnt1, mem_en, mem_rw, busy} !== 5'b01101) begin fails++; $display("FAIL rd1_grant: got %b expected 01101", {gnt0, gnt1, mem_en, mem_rw, busy}); end
        req1 = 0;
        @(negedge clk);
        tests++; if ({gnt1, mem_en, busy, rvalid1} !== 4'b0010) begin fails++; $display("FAIL rd1_resp: got %b expected 0010", {gnt1, mem_en, busy, rvalid1}); end
        @(negedge clk);
        tests++; if ({rvalid0, rvalid1, busy} !== 3'b010) begin fails++; $display("FAIL rd1_rvalid: got %b expected 010", {rvalid0, rvalid1, busy}); end
        tests++; if (rdata1 !== 32'hDEADBEEF) begin fails++; $display("FAIL rd1_data: got %h expected deadbeef", rdata1); end
        tests++; if (rdata0 !== 32'h0) begin fails++; $display("FAIL rd1_other: got %h expected 0", rdata0); end
        @(negedge clk);
        tests++; if ({rvalid1, rdata1} !== {1'b0, 32'hDEADBEEF}) begin fails++; $display("FAIL rd1_hold: got %h expected 0deadbeef", {rvalid1, rdata1}); end
    endtask

    task automatic test_dropped_request();
        req1 = 1; we1 = 1; addr1 = 32'h44;
        #2 req1 = 0;
        @(negedge clk);
        tests++; if ({gnt0, gnt1, mem_en, busy} !== 4'b0) begin fails++; $display("FAIL drop_ignored: got %b expected 0000", {gnt0, gnt1, mem_en, busy}); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        req0 = 1; we0 = 1; addr0 = 32'h30; wdata0 = 32'hA0;
        req1 = 1; we1 = 1; addr1 = 32'h34; wdata1 = 32'hA1;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b10;
`endif
            @(negedge clk);
            tests++; if ({gnt0, gnt1} !== exp_g) begin fails++; $display("FAIL contend_gnt%0d: got %b expected %b", k, {gnt0, gnt1}, exp_g); end
            tests++; if (mem_addr !== (exp_g[1] ? 32'h30 : 32'h34)) begin fails++; $display("FAIL contend_addr%0d: got %h expected %h", k, mem_addr, exp_g[1] ? 32'h30 : 32'h34); end
            if (k == 3) begin
                req0 = 0; req1 = 0;
            end
            @(negedge clk);
            tests++; if ({gnt0, gnt1, busy} !== 3'b0) begin fails++; $display("FAIL contend_idle%0d: got %b expected 000", k, {gnt0, gnt1, busy}); end
        end
    endtask

    task automatic test_reset_abort();
        req0 = 1; we0 = 0; addr0 = 32'h10;
        @(negedge clk);
        tests++; if (gnt0 !== 1'b1) begin fails++; $display("FAIL abort_grant: got %b expected 1", gnt0); end
        req0 = 0;
        @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_inresp: got %b expected 1", busy); end
        #1 rst = 1'b0;
        #1;
        tests++; if ({gnt0, gnt1, mem_en, mem_rw, busy, rvalid0, rvalid1} !== 7'b0) begin fails++; $display("FAIL abort_async: got %b expected 0000000", {gnt0, gnt1, mem_en, mem_rw, busy, rvalid0, rvalid1}); end
        tests++; if ({mem_addr, rdata0, rdata1} !== 96'h0) begin fails++; $display("FAIL abort_data: got %h expected 0", {mem_addr, rdata0, rdata1}); end
        @(negedge clk);
        tests++; if (rvalid0 !== 1'b0) begin fails++; $display("FAIL abort_norvalid: got %b expected 0", rvalid0); end
        rst = 1'b1;
        req0 = 1; we0 = 1; addr0 = 32'h24; wdata0 = 32'h77;
        @(negedge clk);
        tests++; if ({gnt0, mem_en, rvalid0} !== 3'b110) begin fails++; $display("FAIL abort_regrant: got %b expected 110", {gnt0, mem_en, rvalid0}); end
        tests++; if (mem_addr !== 32'h24) begin fails++; $display("FAIL abort_addr: got %h expected 00000024", mem_addr); end
        req0 = 0;
        @(negedge clk);
        tests++; if ({rvalid0, busy} !== 2'b0) begin fails++; $display("FAIL abort_after: got %b expected 00", {rvalid0, busy}); end
    endtask

    task automatic test_back_to_back();
        req0 = 1; we0 = 0; addr0 = 32'h10;
        @(negedge clk);
        tests++; if ({gnt0, mem_rw} !== 2'b10) begin fails++; $display("FAIL b2b_rdgrant: got %b expected 10", {gnt0, mem_rw}); end
        req0 = 0;
        @(negedge clk);
        @(negedge clk);
        tests++; if ({rvalid0, busy} !== 2'b10) begin fails++; $display("FAIL b2b_rvalid: got %b expected 10", {rvalid0, busy}); end
        tests++; if (rdata0 !== 32'hDEADBEEF) begin fails++; $display("FAIL b2b_rdata: got %h expected deadbeef", rdata0); end
        req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h5;
        @(negedge clk);
        tests++; if ({gnt0, gnt1, mem_en, mem_rw, rvalid0} !== 5'b10110) begin fails++; $display("FAIL b2b_wrgrant: got %b expected 10110", {gnt0, gnt1, mem_en, mem_rw, rvalid0}); end
        tests++; if ({mem_addr, mem_wdata} !== {32'h20, 32'h5}) begin fails++; $display("FAIL b2b_wrcmd: got %h expected 0000002000000005", {mem_addr, mem_wdata}); end
        req0 = 0;
        @(negedge clk);
        req1 = 1; we1 = 0; addr1 = 32'h20;
        @(negedge clk);
        req1 = 0;
        @(negedge clk);
        @(negedge clk);
        tests++; if ({rvalid1, rdata1} !== {1'b1, 32'h5}) begin fails++; $display("FAIL b2b_readback: got %h expected 100000005", {rvalid1, rdata1}); end
        tests++; if ({rvalid0, rdata0} !== {1'b0, 32'hDEADBEEF}) begin fails++; $display("FAIL b2b_port0_held: got %h expected 0deadbeef", {rvalid0, rdata0}); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_write();
        test_read_port1();
        test_dropped_request();
        test_contention();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
